// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 direction decoder.
//   - Scan codes for the prefix bytes (E0, F0) and the mapped keys.
//   - Direction indices and one-hot direction constants.
//   - Decoder state enum.
//   - dir_select(): the output-selection rule.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  // Extended (arrow) keys
  localparam logic [7:0] SC_UP_E  = 8'h75;
  localparam logic [7:0] SC_DN_E  = 8'h72;
  localparam logic [7:0] SC_LT_E  = 8'h6B;
  localparam logic [7:0] SC_RT_E  = 8'h74;
  // Plain keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [1:0] IDX_UP = 2'd0;
  localparam logic [1:0] IDX_DN = 2'd1;
  localparam logic [1:0] IDX_LT = 2'd2;
  localparam logic [1:0] IDX_RT = 2'd3;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // Most recent press wins while it is still held; otherwise fall back to
  // a fixed priority so releasing the newest key exposes an older one.
  function automatic logic [3:0] dir_select(input logic [3:0] held,
                                            input logic [1:0] last);
    if (held[last])   dir_select = DIR_UP << last;
    else if (held[0]) dir_select = DIR_UP;
    else if (held[1]) dir_select = DIR_DOWN;
    else if (held[2]) dir_select = DIR_LEFT;
    else if (held[3]) dir_select = DIR_RIGHT;
    else              dir_select = DIR_NONE;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver.
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_ps2_clk/i_ps2_data raw PS/2 pins (asynchronous)
//   o_byte_valid        one-cycle strobe with an accepted byte
//   o_byte_data[7:0]    accepted byte (valid with o_byte_valid)
//   o_frame_err         one-cycle pulse on bad start/parity/stop or timeout
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_prev;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;     // bits 0..9 of the frame, start bit ends at [0]
  logic [TW-1:0] r_to_cnt;

  logic        w_fall;
  logic        w_dat;
  logic [10:0] w_frame;
  logic        w_ok;

  assign w_fall  = r_clk_prev & ~r_clk_sync[1];
  assign w_dat   = r_dat_sync[1];
  // Complete frame as it stands when the stop bit is being sampled.
  assign w_frame = {w_dat, r_shift};
  assign w_ok    = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Synchronizers reset to the idle-high bus level so reset cannot
      // manufacture a falling edge.
      r_clk_sync   <= 2'b11;
      r_dat_sync   <= 2'b11;
      r_clk_prev   <= 1'b1;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_to_cnt     <= '0;
      o_byte_valid <= 1'b0;
      o_byte_data  <= '0;
      o_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
      r_dat_sync   <= {r_dat_sync[0], i_ps2_data};
      r_clk_prev   <= r_clk_sync[1];
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (w_fall) begin
        // An edge always wins over a coincident timeout.
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= '0;
          if (w_ok) begin
            o_byte_valid <= 1'b1;
            o_byte_data  <= w_frame[8:1];
          end else begin
            o_frame_err  <= 1'b1;
          end
        end else begin
          r_shift   <= {w_dat, r_shift[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == TW'(TIMEOUT_CYCLES)) begin
          r_bit_cnt   <= '0;
          r_to_cnt    <= '0;
          o_frame_err <= 1'b1;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: turns PS/2 arrow/WASD/space make and break codes
// into a held one-hot direction and a fire level for the plane logic.
//   i_clk, i_rst         system clock, synchronous active-high reset
//   i_ps2_clk/i_ps2_data raw PS/2 pins
//   o_direction[3:0]     one-hot up/down/left/right, 0000 when none held
//   o_fire               high while space is held
//   o_frame_err          one-cycle pulse when a frame is rejected
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [3:0] o_direction,
  output logic       o_fire,
  output logic       o_frame_err
);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_ps2_clk    (i_ps2_clk),
    .i_ps2_data   (i_ps2_data),
    .o_byte_valid (w_byte_valid),
    .o_byte_data  (w_byte_data),
    .o_frame_err  (o_frame_err)
  );

  dec_state_t r_state;
  logic [3:0] r_held;
  logic [1:0] r_last;
  logic       r_space;

  logic       w_ext, w_brk;
  logic       w_is_dir, w_is_space;
  logic [1:0] w_idx;
  logic [3:0] w_held_nxt;
  logic [1:0] w_last_nxt;
  logic       w_space_nxt;

  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
  assign w_brk = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);

  // Key map. Prefix bytes never match, so they fall through as unmapped.
  always_comb begin
    w_is_dir   = 1'b0;
    w_is_space = 1'b0;
    w_idx      = IDX_UP;
    if (w_ext) begin
      case (w_byte_data)
        SC_UP_E: begin w_is_dir = 1'b1; w_idx = IDX_UP; end
        SC_DN_E: begin w_is_dir = 1'b1; w_idx = IDX_DN; end
        SC_LT_E: begin w_is_dir = 1'b1; w_idx = IDX_LT; end
        SC_RT_E: begin w_is_dir = 1'b1; w_idx = IDX_RT; end
        default: ;
      endcase
    end else begin
      case (w_byte_data)
        SC_W:     begin w_is_dir = 1'b1; w_idx = IDX_UP; end
        SC_S:     begin w_is_dir = 1'b1; w_idx = IDX_DN; end
        SC_A:     begin w_is_dir = 1'b1; w_idx = IDX_LT; end
        SC_D:     begin w_is_dir = 1'b1; w_idx = IDX_RT; end
        SC_SPACE: w_is_space = 1'b1;
        default:  ;
      endcase
    end
  end

  // Held-state update. A typematic make just rewrites the same bit and
  // reloads last; a break of an unheld key clears an already-clear bit.
  always_comb begin
    w_held_nxt  = r_held;
    w_last_nxt  = r_last;
    w_space_nxt = r_space;
    if (w_byte_valid) begin
      if (w_is_dir) begin
        if (w_brk) begin
          w_held_nxt[w_idx] = 1'b0;
        end else begin
          w_held_nxt[w_idx] = 1'b1;
          w_last_nxt        = w_idx;
        end
      end else if (w_is_space) begin
        w_space_nxt = ~w_brk;
      end
    end
  end

  // Outputs are registered from the next-state values so they land one
  // cycle after the byte strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_held      <= '0;
      r_last      <= IDX_UP;
      r_space     <= 1'b0;
      o_direction <= DIR_NONE;
      o_fire      <= 1'b0;
    end else begin
      r_held      <= w_held_nxt;
      r_last      <= w_last_nxt;
      r_space     <= w_space_nxt;
      o_direction <= dir_select(w_held_nxt, w_last_nxt);
      o_fire      <= w_space_nxt;
      if (w_byte_valid) begin
        case (r_state)
          ST_IDLE: begin
            if (w_byte_data == SC_EXT)      r_state <= ST_EXT;
            else if (w_byte_data == SC_BRK) r_state <= ST_BRK;
            else                            r_state <= ST_IDLE;
          end
          ST_EXT:  r_state <= (w_byte_data == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
module tb_ps2_direction_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] direction;
  logic       fire;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  ps2_direction_decoder #(.TIMEOUT_CYCLES(5000)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .o_direction (direction),
    .o_fire      (fire),
    .o_frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
  logic [7:0] wasd   [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
  bit         m_ext, m_brk, m_space;
  bit   [3:0] m_held;
  int         m_last;

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_space = 0; m_held = '0; m_last = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (!m_ext && !m_brk && b == 8'hE0) begin m_ext = 1; return; end
    if (!m_brk && b == 8'hF0) begin m_brk = 1; return; end
    for (int k = 0; k < 4; k++) begin
      if ((m_ext ? arrows[k] : wasd[k]) == b) begin
        if (m_brk) m_held[k] = 0;
        else begin m_held[k] = 1; m_last = k; end
      end
    end
    if (!m_ext && b == 8'h29) m_space = !m_brk;
    m_ext = 0; m_brk = 0;
  endfunction

  function automatic logic [3:0] model_dir();
    if (m_held[m_last]) return 4'(1 << m_last);
    for (int k = 0; k < 4; k++) if (m_held[k]) return 4'(1 << k);
    return 4'b0000;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = (~^b) ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(2);
      ps2_clk = 1'b0;
      wait_cyc(4);
      ps2_clk = 1'b1;
      wait_cyc(2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits(mk_frame(b, bad), 11);
    if (!bad) model_byte(b);
    wait_cyc(4);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         bad;
    logic [3:0] dir;
    bit         fire;
    int         errs;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [7:0] b, input bit bad,
                              input logic [3:0] dir, input bit f, input int errs);
    vec_t v;
    v.b = b; v.bad = bad; v.dir = dir; v.fire = f; v.errs = errs;
    vecs.push_back(v);
  endfunction

  initial begin
    int e0;
    logic [7:0] pool [11] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                              8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
    model_reset();

    // W make/break; arrows with fallback; typematic; parity errors
    add(8'h1D,0,4'b0001,0,0); add(8'hF0,0,4'b0001,0,0); add(8'h1D,0,4'b0000,0,0);
    add(8'hE0,0,4'b0000,0,0); add(8'h6B,0,4'b0100,0,0);
    add(8'h23,0,4'b1000,0,0); add(8'hF0,0,4'b1000,0,0); add(8'h23,0,4'b0100,0,0);
    add(8'hE0,0,4'b0100,0,0); add(8'h75,0,4'b0001,0,0);
    add(8'hE0,0,4'b0001,0,0); add(8'h72,0,4'b0010,0,0);
    add(8'hE0,0,4'b0010,0,0); add(8'hF0,0,4'b0010,0,0); add(8'h72,0,4'b0001,0,0);
    add(8'h29,1,4'b0001,0,1); add(8'h29,0,4'b0001,1,0);
    add(8'hE0,0,4'b0001,1,0); add(8'hF0,0,4'b0001,1,0); add(8'h75,0,4'b0100,1,0);
    add(8'hE0,0,4'b0100,1,0); add(8'hF0,0,4'b0100,1,0); add(8'h6B,0,4'b0000,1,0);
    add(8'hF0,0,4'b0000,1,0); add(8'h29,0,4'b0000,0,0);
    add(8'hF0,0,4'b0000,0,0); add(8'h1B,0,4'b0000,0,0);
    add(8'h55,0,4'b0000,0,0);
    add(8'h1C,0,4'b0100,0,0); add(8'h1D,0,4'b0001,0,0); add(8'h1C,0,4'b0100,0,0);
    add(8'hF0,0,4'b0100,0,0); add(8'h1C,0,4'b0001,0,0);
    add(8'hF0,0,4'b0001,0,0); add(8'h1D,0,4'b0000,0,0);
    add(8'hE0,0,4'b0000,0,0); add(8'hF0,1,4'b0000,0,1); add(8'h74,0,4'b1000,0,0);
    add(8'hE0,0,4'b1000,0,0); add(8'hF0,0,4'b1000,0,0); add(8'h74,0,4'b0000,0,0);
    add(8'hE0,0,4'b0000,0,0); add(8'h1D,0,4'b0000,0,0); add(8'h1D,0,4'b0001,0,0);
    add(8'hF0,0,4'b0001,0,0); add(8'h1D,0,4'b0000,0,0);

    // reset state
    wait_cyc(3);
    check("reset direction", direction, 4'b0000);
    check("reset fire", fire, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_cyc(3);

    foreach (vecs[i]) begin
      e0 = err_cnt;
      send_frame(vecs[i].b, vecs[i].bad);
      check($sformatf("vec%0d direction", i), direction, vecs[i].dir);
      check($sformatf("vec%0d fire", i), fire, vecs[i].fire);
      check($sformatf("vec%0d frame_err pulses", i), err_cnt - e0, vecs[i].errs);
    end

    // exact latency from the stop-bit edge
    send_bits(mk_frame(8'h1D, 0), 10);
    ps2_data = 1'b1;
    wait_cyc(2);
    ps2_clk = 1'b0;
    wait_cyc(3);
    check("latency dir before N+2", direction, 4'b0000);
    wait_cyc(1);
    check("latency dir at N+2", direction, 4'b0001);
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(2);
    model_byte(8'h1D);
    send_frame(8'hF0, 0);
    send_frame(8'h1D, 0);
    check("latency release", direction, 4'b0000);

    // frame_err timing for a bad-parity frame
    send_bits(mk_frame(8'h29, 1), 10);
    ps2_data = 1'b1;
    wait_cyc(2);
    ps2_clk = 1'b0;
    wait_cyc(2);
    check("perr before N+1", frame_err, 1'b0);
    wait_cyc(1);
    check("perr at N+1", frame_err, 1'b1);
    wait_cyc(1);
    check("perr one cycle", frame_err, 1'b0);
    ps2_clk = 1'b1;
    wait_cyc(4);
    check("perr fire", fire, 1'b0);

    // timeout after a 5-bit partial frame
    e0 = err_cnt;
    send_bits(mk_frame(8'h1C, 0), 5);
    wait_cyc(4900);
    check("timeout not early", err_cnt - e0, 0);
    wait_cyc(200);
    check("timeout pulse", err_cnt - e0, 1);
    check("timeout direction", direction, 4'b0000);
    send_frame(8'h1C, 0);
    check("after timeout 1C", direction, 4'b0100);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    check("after timeout release", direction, 4'b0000);

    // reset mid-frame while W and space are held
    send_frame(8'h1D, 0);
    send_frame(8'h29, 0);
    check("pre-reset direction", direction, 4'b0001);
    check("pre-reset fire", fire, 1'b1);
    send_bits(mk_frame(8'h1B, 0), 4);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    check("mid reset direction", direction, 4'b0000);
    check("mid reset fire", fire, 1'b0);
    check("mid reset frame_err", frame_err, 1'b0);
    model_reset();
    send_frame(8'h1B, 0);
    check("after reset 1B", direction, 4'b0010);
    check("after reset fire", fire, 1'b0);

    // randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      logic [7:0] b;
      bit bad;
      b   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 10)];
      bad = ($urandom_range(0, 9) == 0);
      e0  = err_cnt;
      send_frame(b, bad);
      check($sformatf("rand%0d direction", it), direction, model_dir());
      check($sformatf("rand%0d fire", it), fire, m_space);
      check($sformatf("rand%0d frame_err pulses", it), err_cnt - e0, bad ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_direction_decoder.md
# ps2_direction_decoder

Receives PS/2 keyboard frames and turns arrow, WASD and space key make/break codes into the one-hot `direction` and level `fire` signals used by the plane movement/render stage. It sits directly upstream of the plane logic. Its `direction` output is held stable between key events, so the movement stage can sample it on any `clk_move` edge. Malformed or stalled frames are discarded and never change the outputs.

## Interface
- `TIMEOUT_CYCLES`, default 5000: number of `clk` cycles without a PS/2 clock falling edge, mid-frame, before the partial frame is aborted (200 µs at 25 MHz).
- `clk` in 1: system clock (25 MHz pixel clock).
- `rst` in 1: reset, synchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `direction` out 4: one-hot movement request.
  - 0001 up, 0010 down, 0100 left, 1000 right.
  - 0000 when no direction key is held.
- `fire` out 1: high while space is held.
- `frame_err` out 1: one-cycle pulse when a frame is rejected (bad start, parity or stop bit, or timeout).

## Operation
- Both pins pass through 2-flop synchronizers. A falling edge is declared when the synchronized `ps2_clk` goes from 1 (previous) to 0 (current); `ps2_data` is sampled in that cycle.
- The receiver expects 11 bits per frame: start 0, data[7:0] LSB first, odd parity, stop 1.
  - After the 11th bit, the frame is accepted only if start=0, stop=1 and the XOR of data+parity is 1.
  - Otherwise `frame_err` pulses.
  - Either way, the bit counter returns to 0.
- Timeout: a counter clears on every detected edge. It counts only when the bit counter is nonzero. When it reaches `TIMEOUT_CYCLES`, the bit counter clears and `frame_err` pulses.
- Decoder FSM operates on accepted bytes.
  - States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0).
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte is a make code, applied, then the FSM stays in IDLE.
  - EXT: F0 goes to EXT_BRK. Any other byte is an extended make, applied, then IDLE.
  - BRK: byte is a break code, applied, then IDLE.
  - EXT_BRK: byte is an extended break, applied, then IDLE.
- Key map:
  - Extended: 75 up, 72 down, 6B left, 74 right.
  - Plain: 1D (W) up, 1B (S) down, 1C (A) left, 23 (D) right, 29 space.
  - Arrow and WASD for the same direction set and clear the same held bit.
  - Unmapped codes return the FSM to IDLE without changing any state.
- State: `held[3:0]`, `space_held`, `last[1:0]` (index of the most recently pressed direction).
  - A make sets its held bit and loads `last`.
  - A break clears its held bit.
  - Typematic repeats (a make for a key already held) reload `last` only.
- Output rule:
  - If `held[last]` is set, `direction` is onehot(`last`).
  - Otherwise, use fixed priority among the remaining held bits: up > down > left > right.
  - Otherwise `direction` is 0000.
  - `fire` = `space_held`.

## Timing
- Reset values: `direction`=0000, `fire`=0, `frame_err`=0. Held state, `last`, bit counter, timeout counter and FSM (IDLE) all clear.
- Latency: stop bit sampled in cycle N, accepted byte strobe in N+1, FSM/held update in N+1, registered outputs valid in N+2.
- `frame_err` is asserted in cycle N+1 for a bad frame, or in the cycle after the timeout count is reached.
- The pin-to-edge-detect latency is 3 `clk` cycles.
- Reset asserted mid-frame discards the partial frame. The first edge after reset is treated as the start bit.
- A break for a key not held has no effect.
- A rejected frame leaves the FSM state unchanged.
- Simultaneous timeout and edge: the edge wins, i.e. the counter clears and no abort occurs.

## Structure
- Package `ps2_pkg`: scan-code constants (E0, F0, the key codes above), direction one-hot constants, decoder state enum.
- Sub-module `ps2_rx` contains:
  - the synchronizers, edge detector, bit shifter, parity/timeout checker;
  - outputs `byte_valid`, `byte_data[7:0]`, `frame_err`.
- The top level holds the FSM, held/last registers and output logic.

## Test plan
- Frames 1D, F0 1D → `direction`=0001 two cycles after the first stop bit, then 0000 after the break.
- E0 6B (hold), then 23 (hold) → 0100 then 1000. Then F0 23 → 0100 (fallback to the still-held left).
- Hold 75 and 72 extended, release 72 (E0 F0 72) → direction goes 0001, then 0010, then 0001.
- Frame 29 with a flipped parity bit → `frame_err` pulses once, `fire` stays 0. A good 29 then gives `fire`=1.
- 5 bits of a frame, then idle for 5000 cycles → `frame_err` pulse. The next full frame 1C gives 0100.
- Hold W, assert `rst` for 1 cycle mid-frame → all outputs are 0 next cycle, and a following clean 1B frame gives 0010.
